// File: rtl/spi_reg_slave.sv
// SPI mode-0 register-file responder, oversampled in the clk domain.
// Command byte {rw, addr[6:0]}, then burst data bytes with wrapping address.
module spi_reg_slave #(
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              busy,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s, cs_s, mosi_s, rise, fall;

  state_e            state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [6:0]        cmd_sr_q, cmd_sr_d;
  logic [6:0]        rx_sr_q, rx_sr_d;
  // miso_q holds the top bit of the outgoing byte; tx_sr_q holds the rest.
  logic [6:0]        tx_sr_q, tx_sr_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_nxt;
  logic              rw_q, rw_d;
  logic              inv_q, inv_d;
  logic              miso_q, miso_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        rd_data_q;
  logic [7:0]        regs_q [NREG];
  logic              reg_we;
  logic [7:0]        cmd_byte, data_byte, load_byte;
  logic              cmd_inv;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_prev_q;
  assign fall   = ~sclk_s & sclk_prev_q;

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    cmd_sr_d    = cmd_sr_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    inv_d       = inv_q;
    miso_d      = miso_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    reg_we      = 1'b0;
    load_byte   = 8'h00;
    cmd_byte    = {cmd_sr_q, mosi_s};
    data_byte   = {rx_sr_q, mosi_s};
    cmd_inv     = (cmd_byte[6:0] >> ADDR_W) != 7'd0;
    addr_nxt    = addr_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (!cs_s) begin
          state_d  = CMD;
          bitcnt_d = 3'd0;
          miso_d   = 1'b0;
        end
      end
      CMD, DATA: begin
        if (cs_s) begin
          state_d  = IDLE;
          bitcnt_d = 3'd0;
          cmd_sr_d = 7'd0;
          rx_sr_d  = 7'd0;
          tx_sr_d  = 7'd0;
          miso_d   = 1'b0;
        end else if (state_q == CMD) begin
          if (rise) begin
            cmd_sr_d = cmd_byte[6:0];
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              state_d  = DATA;
              bitcnt_d = 3'd0;
              rw_d     = cmd_byte[7];
              addr_d   = cmd_byte[ADDR_W-1:0];
              inv_d    = cmd_inv;
              if (cmd_byte[7] && !cmd_inv) load_byte = regs_q[cmd_byte[ADDR_W-1:0]];
              miso_d   = load_byte[7];
              tx_sr_d  = load_byte[6:0];
            end
          end
        end else begin
          if (rise) begin
            rx_sr_d  = data_byte[6:0];
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              bitcnt_d = 3'd0;
              addr_d   = addr_nxt;
              if (!rw_q && !inv_q) begin
                reg_we      = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = addr_q;
                wr_data_d   = data_byte;
              end
              if (rw_q && !inv_q) load_byte = regs_q[addr_nxt];
              miso_d  = load_byte[7];
              tx_sr_d = load_byte[6:0];
            end
          end else if (fall && bitcnt_q != 3'd0) begin
            miso_d  = tx_sr_q[6];
            tx_sr_d = {tx_sr_q[5:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      state_q     <= IDLE;
      bitcnt_q    <= 3'd0;
      cmd_sr_q    <= 7'd0;
      rx_sr_q     <= 7'd0;
      tx_sr_q     <= 7'd0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      inv_q       <= 1'b0;
      miso_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      rd_data_q   <= 8'h00;
      for (int i = 0; i < NREG; i++) regs_q[i] <= 8'h00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      cmd_sr_q    <= cmd_sr_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      inv_q       <= inv_d;
      miso_q      <= miso_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      // Local read sees the pre-commit value when both hit the same address.
      rd_data_q   <= regs_q[rd_addr];
      if (reg_we) regs_q[addr_q] <= data_byte;
    end
  end

  assign miso      = miso_q;
  assign busy      = (state_q != IDLE);
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: SPI master model driving frames, byte-level
// register model predicting read data, write strobes and register contents.
module tb_spi_reg_slave;
  localparam int ADDR_W = 3;
  localparam int HALF   = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic [2:0] rd_addr = 3'd0;
  logic       miso, busy, wr_strobe;
  logic [2:0] wr_addr;
  logic [7:0] wr_data, rd_data;

  spi_reg_slave #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .busy(busy), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0]  mregs [8];
  logic [10:0] exp_wr [$];
  logic [10:0] obs_wr [$];
  logic [7:0]  dbytes [8];
  logic        prev_strobe = 1'b0;

  always @(negedge clk) begin
    if (rst_n && wr_strobe) begin
      obs_wr.push_back({wr_addr, wr_data});
      chk("strobe_width", 32'(prev_strobe), 32'd0);
    end
    prev_strobe = wr_strobe;
  end

  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    repeat (HALF) @(negedge clk);
    r = miso;
    sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic check_regs();
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      @(negedge clk);
      chk("rd_data", 32'(rd_data), 32'(mregs[i]));
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input int nb, input int part);
    logic [7:0] rx;
    logic       ok, b;
    logic [2:0] a;
    ok = (cmd[6:3] == 4'd0);
    a  = cmd[2:0];
    @(negedge clk);
    cs = 1'b0;
    repeat (2) @(negedge clk);
    spi_byte(cmd, rx);
    chk("miso_cmd", 32'(rx), 32'd0);
    for (int k = 0; k < nb; k++) begin
      spi_byte(dbytes[k], rx);
      if (cmd[7]) begin
        chk("rd_byte", 32'(rx), ok ? 32'(mregs[a]) : 32'd0);
      end else begin
        chk("miso_wr", 32'(rx), 32'd0);
        if (ok) begin
          mregs[a] = dbytes[k];
          exp_wr.push_back({a, dbytes[k]});
        end
      end
      a = a + 3'd1;
    end
    for (int j = 0; j < part; j++) spi_bit(dbytes[nb][7-j], b);
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("miso_idle", 32'(miso), 32'd0);
    repeat (4) @(negedge clk);
    chk("wr_count", 32'(obs_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++)
      chk("wr_entry", 32'(obs_wr[i]), 32'(exp_wr[i]));
    obs_wr.delete();
    exp_wr.delete();
    check_regs();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx, cmd;
    logic       b;
    int         nb, part;
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobe", 32'(wr_strobe), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    check_regs();

    dbytes[0] = 8'hA5; run_frame(8'h02, 1, 0);
    dbytes[0] = 8'h00; run_frame(8'h82, 1, 0);
    dbytes[0] = 8'h11; dbytes[1] = 8'h22; dbytes[2] = 8'h33;
    run_frame(8'h07, 3, 0);
    run_frame(8'h87, 3, 0);
    dbytes[0] = 8'hFF; run_frame(8'h10, 1, 0);
    dbytes[0] = 8'h00; run_frame(8'h90, 1, 0);
    dbytes[0] = 8'hC3; run_frame(8'h03, 0, 4);
    dbytes[0] = 8'h5A; run_frame(8'h03, 1, 0);

    // Reset in the middle of data bit 3 of a read of reg 2.
    rd_addr = 3'd2;
    @(negedge clk);
    cs = 1'b0;
    repeat (2) @(negedge clk);
    spi_byte(8'h82, rx);
    spi_bit(1'b0, b);
    spi_bit(1'b0, b);
    mosi = 1'b0;
    repeat (HALF) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_miso", 32'(miso), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rd_data", 32'(rd_data), 32'd0);
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    @(negedge clk);
    sclk = 1'b0;
    cs = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    obs_wr.delete();
    check_regs();
    dbytes[0] = 8'h00; run_frame(8'h82, 1, 0);

    for (int t = 0; t < 30; t++) begin
      cmd = 8'($urandom);
      if ($urandom_range(3) != 0) cmd[6:3] = 4'd0;
      nb = int'($urandom_range(0, 4));
      part = ($urandom_range(3) == 0) ? int'($urandom_range(1, 7)) : 0;
      for (int k = 0; k < 8; k++) dbytes[k] = 8'($urandom);
      run_frame(cmd, nb, part);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
